// File: rtl/matrix_addr_sweep_gen.sv
// Multi-lane address sweeper: issues LANES consecutive addresses per beat from a
// runtime base over a runtime length, with backpressure, tail lane mask and wrap.
module matrix_addr_sweep_gen #(
  parameter int ADDR_W = 14,
  parameter int LANES  = 8,
  parameter int LEN_W  = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      ready,
  output logic                      valid,
  output logic [LANES*ADDR_W-1:0]   addr,
  output logic [LANES-1:0]          lane_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int REM_W = LEN_W + 1;
  localparam logic [REM_W-1:0]  LANES_REM  = REM_W'(LANES);
  localparam logic [ADDR_W-1:0] LANES_ADDR = ADDR_W'(LANES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  cur_addr_r, cur_addr_s;
  logic [REM_W-1:0]   remaining_r, remaining_s;

  // State, current base address and remaining count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= '0;
      remaining_r <= '0;
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      remaining_r <= remaining_s;
    end
  end

  // Next-state logic; the final beat leaves cur_addr untouched so addr holds in DONE
  always_comb begin
    state_s     = state_r;
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cur_addr_s  = cfg_base;
          remaining_s = {1'b0, cfg_len};
          if (cfg_len == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (ready) begin
          if (remaining_r <= LANES_REM) begin
            remaining_s = '0;
            state_s     = ST_DONE;
          end else begin
            remaining_s = remaining_r - LANES_REM;
            cur_addr_s  = cur_addr_r + LANES_ADDR;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Lane address and mask decode from registered state only
  always_comb begin
    addr       = '0;
    lane_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state_r == ST_IDLE) begin
        addr[i*ADDR_W +: ADDR_W] = '0;
      end else begin
        addr[i*ADDR_W +: ADDR_W] = cur_addr_r + ADDR_W'(i);
      end
      if (state_r == ST_RUN) begin
        lane_valid[i] = (REM_W'(i) < remaining_r);
      end else begin
        lane_valid[i] = 1'b0;
      end
    end
  end

  assign valid = (state_r == ST_RUN);
  assign busy  = (state_r == ST_RUN);
  assign done  = (state_r == ST_DONE);

endmodule

// File: tb/tb_matrix_addr_sweep_gen.sv
// Self-checking bench for matrix_addr_sweep_gen against a beat-list reference model.
module tb_matrix_addr_sweep_gen;

  localparam int ADDR_W = 14;
  localparam int LANES  = 8;
  localparam int LEN_W  = 14;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic [ADDR_W-1:0]        cfg_base;
  logic [LEN_W-1:0]         cfg_len;
  logic                     ready;
  logic                     valid;
  logic [LANES*ADDR_W-1:0]  addr;
  logic [LANES-1:0]         lane_valid;
  logic                     busy;
  logic                     done;

  int checks = 0;
  int errors = 0;

  matrix_addr_sweep_gen #(.ADDR_W(ADDR_W), .LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .ready(ready), .valid(valid), .addr(addr), .lane_valid(lane_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected lanes of beat b: base + b*LANES + i, modulo 2^ADDR_W
  function automatic logic [LANES*ADDR_W-1:0] model_addr(input int base, input int b);
    logic [LANES*ADDR_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ADDR_W +: ADDR_W] = ADDR_W'(base + b*LANES + i);
    return v;
  endfunction

  // Expected mask of beat b: lane i carries an address while i < len - b*LANES
  function automatic logic [LANES-1:0] model_mask(input int len, input int b);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (i < (len - b*LANES));
    return m;
  endfunction

  // rmode: 0 = ready held, 1 = pattern 1,0,0,1,0,1, 2 = random; inj: start pulse mid-run
  task automatic sweep_scenario(input string name, input int base, input int len,
                                input int rmode, input bit inj);
    int nbeats, b, cyc, bound;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    logic r;
    logic [LANES*ADDR_W-1:0] ea;
    logic [LANES-1:0] em;
    nbeats = (len + LANES - 1) / LANES;
    bound  = nbeats * 20 + 50;
    cfg_base = ADDR_W'(base);
    cfg_len  = LEN_W'(len);
    start = 1'b1;
    ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base = ADDR_W'($urandom);
    cfg_len  = LEN_W'($urandom);
    if (len == 0) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
          errors++;
          $display("FAIL %s zero_len cyc %0d got valid=%b busy=%b done=%b exp 0 0 1",
                   name, k, valid, busy, done);
        end
        @(posedge clk); #1;
      end
    end else begin
      b = 0;
      cyc = 0;
      while (b < nbeats && cyc < bound) begin
        ea = model_addr(base, b);
        em = model_mask(len, b);
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s flags beat %0d got valid=%b busy=%b done=%b exp 1 1 0",
                   name, b, valid, busy, done);
        end
        checks++;
        if (addr !== ea) begin
          errors++;
          $display("FAIL %s addr beat %0d got %h exp %h", name, b, addr, ea);
        end
        checks++;
        if (lane_valid !== em) begin
          errors++;
          $display("FAIL %s lane_valid beat %0d got %h exp %h", name, b, lane_valid, em);
        end
        case (rmode)
          0: r = 1'b1;
          1: r = (pat[cyc % 6] != 0);
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        ready = r;
        if (inj && cyc == 1) begin
          start = 1'b1;
          cfg_base = ADDR_W'($urandom);
          cfg_len = LEN_W'($urandom_range(1, 50));
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        if (r) b++;
        cyc++;
      end
      ready = 1'b0;
      start = 1'b0;
      checks++;
      if (b < nbeats) begin
        errors++;
        $display("FAIL %s timeout got %0d beats exp %0d", name, b, nbeats);
      end
      ea = model_addr(base, nbeats - 1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || lane_valid !== '0) begin
          errors++;
          $display("FAIL %s end_flags cyc %0d got valid=%b busy=%b done=%b lv=%h exp 0 0 1 0",
                   name, k, valid, busy, done, lane_valid);
        end
        checks++;
        if (addr !== ea) begin
          errors++;
          $display("FAIL %s end_addr_hold got %h exp %h", name, addr, ea);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr !== '0 || lane_valid !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b busy=%b done=%b addr=%h lv=%h exp all 0",
               valid, busy, done, addr, lane_valid);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_long_sweep();
    sweep_scenario("long", 32'h1000, 4096, 0, 1'b0);
  endtask

  task automatic test_partial();
    sweep_scenario("partial", 32'h0200, 13, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sweep_scenario("backpressure", int'($urandom_range(0, 16383)), 24, 1, 1'b0);
  endtask

  task automatic test_wrap();
    sweep_scenario("wrap", 32'h3FFC, 8, 0, 1'b0);
    sweep_scenario("wrap_multi", 32'h3FF9, 21, 2, 1'b0);
  endtask

  task automatic test_zero_len();
    sweep_scenario("zero_len", 32'h0123, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int base;
    int b;
    int cyc;
    base = int'($urandom_range(0, 16383));
    cfg_base = ADDR_W'(base);
    cfg_len = LEN_W'(64);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ready = 1'b1;
    b = 0;
    cyc = 0;
    while (b < 3 && cyc < 20) begin
      @(posedge clk); #1;
      if (valid === 1'b1) b++;
      cyc++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run got valid=%b busy=%b done=%b exp 0 0 0", valid, busy, done);
    end
    ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after got valid=%b done=%b exp 0 0", valid, done);
    end
    sweep_scenario("restart", int'($urandom_range(0, 16383)), 37, 2, 1'b0);
  endtask

  task automatic test_start_in_run();
    sweep_scenario("start_in_run", int'($urandom_range(0, 16383)), 40, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      sweep_scenario("random", int'($urandom_range(0, 16383)),
                     (n % 5 == 4) ? 0 : int'($urandom_range(1, 70)), 2, n[0]);
    end
  endtask

  initial begin
    test_reset();
    test_long_sweep();
    test_partial();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_mid_run();
    test_start_in_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
